// File: rtl/rr_arbiter_8to1_if.sv
// Request/grant bundle between the requesting agents and the round-robin arbiter.
// master drives requests and observes grants; slave is the arbiter side.
interface rr_arbiter_8to1_if;
   logic [7:0] req;
   logic [7:0] grant;
   logic [2:0] grant_id;
   logic       grant_valid;
   logic       timeout;

   modport master (
      output req,
      input  grant,
      input  grant_id,
      input  grant_valid,
      input  timeout
   );

   modport slave (
      input  req,
      output grant,
      output grant_id,
      output grant_valid,
      output timeout
   );
endinterface

// File: rtl/rr_arbiter_8to1.sv
// Eight-requester round-robin arbiter with a registered one-hot grant and binary index.
// Define ARB_TIMEOUT_EN to build the hold watchdog that revokes grants after HOLD_MAX cycles.
module rr_arbiter_8to1 #(
   parameter int unsigned HOLD_MAX = 16
) (
   input logic               clk,
   input logic               rst_n,
   rr_arbiter_8to1_if.slave  bus
);

   typedef enum logic [0:0] {StIdle, StGrant} state_e;

   state_e     state_q, state_d;
   logic [2:0] owner_q, owner_d;
   logic [2:0] ptr_q, ptr_d;
   logic [7:0] arb_req;
   logic [2:0] winner;
   logic       found;
   logic       revoke;
   logic       keep;
   logic       new_grant;

`ifdef ARB_TIMEOUT_EN
   localparam int unsigned HoldW = $clog2(HOLD_MAX + 1);

   logic [HoldW-1:0] hold_q, hold_d;
   logic             timeout_q;

   assign revoke = (state_q == StGrant) && bus.req[owner_q] && (hold_q == HoldW'(HOLD_MAX));
`else
   assign revoke = 1'b0;
`endif

   assign keep = (state_q == StGrant) && bus.req[owner_q] && !revoke;

   // A revoked owner is masked for this one decision only.
   always_comb begin
      arb_req = bus.req;
      if (revoke) begin
         arb_req[owner_q] = 1'b0;
      end
   end

   // Search upward from ptr, wrapping 7 -> 0; first set bit wins.
   always_comb begin
      found  = 1'b0;
      winner = 3'd0;
      for (int unsigned i = 0; i < 8; i++) begin
         if (!found && arb_req[ptr_q + 3'(i)]) begin
            found  = 1'b1;
            winner = ptr_q + 3'(i);
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      ptr_d     = ptr_q;
      new_grant = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (found) begin
               new_grant = 1'b1;
            end
         end
         StGrant: begin
            if (!keep) begin
               if (found) begin
                  new_grant = 1'b1;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
      if (new_grant) begin
         state_d = StGrant;
         owner_d = winner;
         ptr_d   = winner + 3'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         owner_q <= 3'd0;
         ptr_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
      end
   end

`ifdef ARB_TIMEOUT_EN
   always_comb begin
      hold_d = hold_q;
      if (new_grant) begin
         hold_d = HoldW'(1);
      end else if (keep) begin
         hold_d = hold_q + HoldW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hold_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         hold_q    <= hold_d;
         timeout_q <= revoke;
      end
   end

   assign bus.timeout = timeout_q;
`else
   assign bus.timeout = 1'b0;
`endif

   assign bus.grant       = (state_q == StGrant) ? (8'd1 << owner_q) : 8'd0;
   assign bus.grant_id    = (state_q == StGrant) ? owner_q : 3'd0;
   assign bus.grant_valid = (state_q == StGrant);

endmodule

// File: tb/tb_rr_arbiter_8to1.sv
// Self-checking bench for rr_arbiter_8to1: directed plan steps plus randomized traffic
// compared each cycle against a behavioural ownership model.
module tb_rr_arbiter_8to1;

`ifdef ARB_TIMEOUT_EN
   localparam bit Wd = 1'b1;
`else
   localparam bit Wd = 1'b0;
`endif
   localparam int Hold = 4;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   // Reference model: owner index (-1 = none), priority pointer, cycles held, timeout flag.
   int m_owner;
   int m_ptr;
   int m_hold;
   bit m_to;

   rr_arbiter_8to1_if bus ();

   rr_arbiter_8to1 #(.HOLD_MAX(Hold)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input logic [7:0] r, input logic rn);
      bit         revoke;
      logic [7:0] vec;
      int         w;
      if (!rn) begin
         m_owner = -1;
         m_ptr   = 0;
         m_hold  = 0;
         m_to    = 1'b0;
         return;
      end
      revoke = Wd && (m_owner >= 0) && r[m_owner] && (m_hold == Hold);
      if ((m_owner >= 0) && r[m_owner] && !revoke) begin
         m_hold++;
         m_to = 1'b0;
      end else begin
         vec = r;
         if (revoke) vec[m_owner] = 1'b0;
         m_to = revoke;
         w = -1;
         for (int i = 0; i < 8; i++) begin
            if (w < 0 && vec[(m_ptr + i) % 8]) w = (m_ptr + i) % 8;
         end
         if (w >= 0) begin
            m_owner = w;
            m_ptr   = (w + 1) % 8;
            m_hold  = 1;
         end else begin
            m_owner = -1;
         end
      end
   endtask

   // Apply one clock of stimulus, advance the model, then compare all outputs off-edge.
   task automatic cycle(input logic [7:0] r, input logic rn);
      logic [7:0] eg;
      logic [2:0] eid;
      bus.req = r;
      rst_n   = rn;
      @(posedge clk);
      model_edge(r, rn);
      #1;
      eg  = (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
      eid = (m_owner < 0) ? 3'd0 : 3'(m_owner);
      check("model_grant", bus.grant, eg);
      check("model_grant_id", {5'd0, bus.grant_id}, {5'd0, eid});
      check("model_grant_valid", {7'd0, bus.grant_valid}, {7'd0, (m_owner >= 0)});
      check("model_timeout", {7'd0, bus.timeout}, {7'd0, m_to});
      check("onehot0", {7'd0, $onehot0(bus.grant)}, 8'd1);
   endtask

   initial begin
      logic [7:0] r;
      checks  = 0;
      errors  = 0;
      m_owner = -1;
      m_ptr   = 0;
      m_hold  = 0;
      m_to    = 1'b0;
      bus.req = 8'h00;
      rst_n   = 1'b0;

      // Reset values
      cycle(8'hFF, 1'b0);
      cycle(8'hFF, 1'b0);
      check("rst_grant", bus.grant, 8'h00);
      check("rst_grant_id", {5'd0, bus.grant_id}, 8'h00);
      check("rst_valid", {7'd0, bus.grant_valid}, 8'h00);
      check("rst_timeout", {7'd0, bus.timeout}, 8'h00);

      // Fairness rotation: each owner drops its bit for one cycle after being granted
      cycle(8'hFF, 1'b1);
      check("rot_first", bus.grant, 8'h01);
      for (int k = 0; k < 8; k++) begin
         cycle(8'hFF & ~(8'h01 << k), 1'b1);
         check("rot_grant", bus.grant, 8'h01 << ((k + 1) % 8));
         check("rot_id", {5'd0, bus.grant_id}, 8'((k + 1) % 8));
      end

      // Idle then single requester with one-cycle latency
      for (int i = 0; i < 5; i++) begin
         cycle(8'h00, 1'b1);
         check("idle_grant", bus.grant, 8'h00);
         check("idle_valid", {7'd0, bus.grant_valid}, 8'h00);
      end
      bus.req = 8'h20;
      #1;
      check("no_comb_path", bus.grant, 8'h00);
      cycle(8'h20, 1'b1);
      check("single_grant", bus.grant, 8'h20);
      check("single_id", {5'd0, bus.grant_id}, 8'd5);
      check("single_valid", {7'd0, bus.grant_valid}, 8'd1);

      // Owner 3 releases while 7 waits, then wrap to 0
      cycle(8'h08, 1'b1);
      check("own3", bus.grant, 8'h08);
      cycle(8'h88, 1'b1);
      check("own3_hold", bus.grant, 8'h08);
      cycle(8'h80, 1'b1);
      check("handoff7", bus.grant, 8'h80);
      check("handoff7_id", {5'd0, bus.grant_id}, 8'd7);
      cycle(8'h01, 1'b1);
      check("wrap0", bus.grant, 8'h01);

      // Mid-grant reset drops owner 2 and returns ptr to 0
      cycle(8'h04, 1'b1);
      check("own2", bus.grant, 8'h04);
      cycle(8'h04, 1'b0);
      check("midrst_grant", bus.grant, 8'h00);
      check("midrst_timeout", {7'd0, bus.timeout}, 8'h00);
      cycle(8'h44, 1'b1);
      check("post_rst_ptr", bus.grant, 8'h04);

      // Single agent held constantly
      cycle(8'h00, 1'b0);
      for (int c = 1; c <= 15; c++) begin
         cycle(8'h01, 1'b1);
         if (Wd) begin
            check("wd1_valid", {7'd0, bus.grant_valid}, {7'd0, ((c - 1) % 5) != 4});
            check("wd1_timeout", {7'd0, bus.timeout}, {7'd0, ((c - 1) % 5) == 4});
         end else begin
            check("hold1_grant", bus.grant, 8'h01);
            check("hold1_timeout", {7'd0, bus.timeout}, 8'h00);
         end
      end

      // Two agents held constantly
      cycle(8'h00, 1'b0);
      for (int c = 1; c <= 12; c++) begin
         cycle(8'h03, 1'b1);
         if (Wd) begin
            check("wd2_grant", bus.grant, (((c - 1) / 4) % 2 == 0) ? 8'h01 : 8'h02);
            check("wd2_timeout", {7'd0, bus.timeout}, {7'd0, (c > 1) && ((c - 1) % 4 == 0)});
         end else begin
            check("hold2_grant", bus.grant, 8'h01);
            check("hold2_timeout", {7'd0, bus.timeout}, 8'h00);
         end
      end

      // Randomized traffic; owners mostly keep requesting, occasional resets
      for (int i = 0; i < 600; i++) begin
         r = 8'($urandom) & 8'($urandom);
         if (m_owner >= 0 && $urandom_range(0, 4) != 0) r[m_owner] = 1'b1;
         cycle(r, ($urandom_range(0, 60) != 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
